mips32_mem_responder: RTL and testbench

//  Memory-side responder for the MIPS32 pipeline's instruction-fetch and load/store traffic.

---
 rtl/mips32_mem_responder_if.sv | 34 +++
 rtl/mips32_mem_responder.sv | 169 ++++++++++++++++
 tb/tb_mips32_mem_responder.sv | 291 +++++++++++++++++++++++++++++
 3 files changed

// File: rtl/mips32_mem_responder_if.sv
// Bus bundle between the MIPS32 pipeline (master) and the memory responder
// (slave): fetch port (i_*) and load/store port (d_*), each with a
// valid/ready request channel and a one-cycle response pulse.
interface mips32_mem_responder_if;
   logic        i_req_valid;
   logic        i_req_ready;
   logic [31:0] i_req_addr;
   logic        i_rsp_valid;
   logic [31:0] i_rsp_data;
   logic        i_rsp_err;

   logic        d_req_valid;
   logic        d_req_ready;
   logic        d_req_we;
   logic [31:0] d_req_addr;
   logic [31:0] d_req_wdata;
   logic        d_rsp_valid;
   logic [31:0] d_rsp_rdata;
   logic        d_rsp_err;

   modport master (
      output i_req_valid, i_req_addr,
      input  i_req_ready, i_rsp_valid, i_rsp_data, i_rsp_err,
      output d_req_valid, d_req_we, d_req_addr, d_req_wdata,
      input  d_req_ready, d_rsp_valid, d_rsp_rdata, d_rsp_err
   );

   modport slave (
      input  i_req_valid, i_req_addr,
      output i_req_ready, i_rsp_valid, i_rsp_data, i_rsp_err,
      input  d_req_valid, d_req_we, d_req_addr, d_req_wdata,
      output d_req_ready, d_rsp_valid, d_rsp_rdata, d_rsp_err
   );
endinterface

// File: rtl/mips32_mem_responder.sv
// MIPS32 memory responder: single-port DEPTH x 32 memory shared by the fetch
// and load/store ports. Round-robin arbitration, one transaction in flight,
// response returned LATENCY cycles after accept as a one-cycle pulse.
// Optional feature macro: MEM_BOUNDS_CHECK_EN -- when defined, addresses at or
// above DEPTH are flagged with *_rsp_err, never written and read back as 0;
// when undefined, addresses wrap modulo DEPTH and *_rsp_err stays 0.
module mips32_mem_responder #(
   parameter int DEPTH   = 1024,
   parameter int LATENCY = 2
) (
   input  logic                 clk,
   input  logic                 rst,
   mips32_mem_responder_if.slave bus
);
   localparam int         AW       = $clog2(DEPTH);
   localparam logic [1:0] CNT_INIT = 2'(LATENCY - 1);
`ifdef MEM_BOUNDS_CHECK_EN
   localparam logic       BOUNDS_EN = 1'b1;
`else
   localparam logic       BOUNDS_EN = 1'b0;
`endif

   typedef enum logic [0:0] {IDLE = 1'b0, WAIT = 1'b1} state_t;

   state_t      state_r;
   state_t      state_nxt_s;
   logic [1:0]  cnt_r;
   logic        rr_d_r;        // 1: D port wins when both request
   logic        port_d_r;      // latched owner of the in-flight op
   logic        we_r;
   logic        oob_r;
   logic [AW-1:0] addr_r;
   logic [31:0] wdata_r;
   logic [31:0] mem_r [DEPTH];

   logic        grant_i_s;
   logic        grant_d_s;
   logic        accept_s;
   logic        fire_s;
   logic        i_oob_s;
   logic        d_oob_s;

   logic        i_rsp_valid_r;
   logic [31:0] i_rsp_data_r;
   logic        i_rsp_err_r;
   logic        d_rsp_valid_r;
   logic [31:0] d_rsp_rdata_r;
   logic        d_rsp_err_r;

   // Any nonzero bit above the index range means the word lies outside memory.
   function automatic logic out_of_range(input logic [31:0] a);
      return BOUNDS_EN & (|a[31:AW]);
   endfunction

   assign i_oob_s  = out_of_range(bus.i_req_addr);
   assign d_oob_s  = out_of_range(bus.d_req_addr);
   assign accept_s = grant_i_s | grant_d_s;
   assign fire_s   = (state_r == WAIT) && (cnt_r == 2'd0);

   // State register.
   always_ff @(posedge clk) begin
      if (rst) begin
         state_r <= IDLE;
      end else begin
         state_r <= state_nxt_s;
      end
   end

   // Next-state logic: IDLE -> WAIT on accept, WAIT -> IDLE when the counter expires.
   always_comb begin
      state_nxt_s = state_r;
      case (state_r)
         IDLE: begin
            if (accept_s) begin
               state_nxt_s = WAIT;
            end else begin
               state_nxt_s = IDLE;
            end
         end
         WAIT: begin
            if (cnt_r == 2'd0) begin
               state_nxt_s = IDLE;
            end else begin
               state_nxt_s = WAIT;
            end
         end
         default: state_nxt_s = IDLE;
      endcase
   end

   // Output logic: grant/ready only in IDLE, based solely on the two valids and rr pointer.
   always_comb begin
      grant_i_s = 1'b0;
      grant_d_s = 1'b0;
      if (state_r == IDLE) begin
         if (bus.d_req_valid && (!bus.i_req_valid || rr_d_r)) begin
            grant_d_s = 1'b1;
         end else if (bus.i_req_valid) begin
            grant_i_s = 1'b1;
         end else begin
            grant_i_s = 1'b0;
         end
      end else begin
         grant_d_s = 1'b0;
      end
      bus.i_req_ready = grant_i_s;
      bus.d_req_ready = grant_d_s;
   end

   // Latch the accepted request, flip the rr pointer, and run the latency counter.
   always_ff @(posedge clk) begin
      if (rst) begin
         cnt_r    <= 2'd0;
         rr_d_r   <= 1'b1;
         port_d_r <= 1'b0;
         we_r     <= 1'b0;
         oob_r    <= 1'b0;
         addr_r   <= '0;
         wdata_r  <= 32'd0;
      end else if (accept_s) begin
         cnt_r    <= CNT_INIT;
         rr_d_r   <= grant_i_s;
         port_d_r <= grant_d_s;
         we_r     <= grant_d_s & bus.d_req_we;
         oob_r    <= grant_d_s ? d_oob_s : i_oob_s;
         addr_r   <= grant_d_s ? bus.d_req_addr[AW-1:0] : bus.i_req_addr[AW-1:0];
         wdata_r  <= bus.d_req_wdata;
      end else if ((state_r == WAIT) && (cnt_r != 2'd0)) begin
         cnt_r    <= cnt_r - 2'd1;
      end
   end

   // Response registers: pulse the owning port's valid at the response edge with read data.
   always_ff @(posedge clk) begin
      if (rst) begin
         i_rsp_valid_r <= 1'b0;
         i_rsp_data_r  <= 32'd0;
         i_rsp_err_r   <= 1'b0;
         d_rsp_valid_r <= 1'b0;
         d_rsp_rdata_r <= 32'd0;
         d_rsp_err_r   <= 1'b0;
      end else begin
         i_rsp_valid_r <= fire_s && !port_d_r;
         i_rsp_err_r   <= fire_s && !port_d_r && oob_r;
         d_rsp_valid_r <= fire_s && port_d_r;
         d_rsp_err_r   <= fire_s && port_d_r && oob_r;
         if (fire_s && !port_d_r) begin
            i_rsp_data_r <= oob_r ? 32'd0 : mem_r[addr_r];
         end
         if (fire_s && port_d_r) begin
            d_rsp_rdata_r <= (oob_r || we_r) ? 32'd0 : mem_r[addr_r];
         end
      end
   end

   // Memory write port: stores commit at the response edge unless reset or out of range.
   always_ff @(posedge clk) begin
      if (!rst && fire_s && port_d_r && we_r && !oob_r) begin
         mem_r[addr_r] <= wdata_r;
      end
   end

   assign bus.i_rsp_valid = i_rsp_valid_r;
   assign bus.i_rsp_data  = i_rsp_data_r;
   assign bus.i_rsp_err   = i_rsp_err_r;
   assign bus.d_rsp_valid = d_rsp_valid_r;
   assign bus.d_rsp_rdata = d_rsp_rdata_r;
   assign bus.d_rsp_err   = d_rsp_err_r;
endmodule

// File: tb/tb_mips32_mem_responder.sv
// Scoreboard bench for mips32_mem_responder: drivers push expected responses
// computed from a word-array reference model; a negedge monitor pops and checks.
module tb_mips32_mem_responder;
   localparam int DEPTH   = 1024;
   localparam int LATENCY = 2;

   typedef struct {
      logic [31:0] data;
      logic        err;
      bit          chk;   // data known to the model
      int          due;   // cycle count at which the pulse must be visible
   } exp_t;

   logic clk = 1'b0;
   logic rst = 1'b1;
   int   cyc = 0;
   int   n_checks = 0;
   int   n_fail = 0;
   exp_t i_q[$];
   exp_t d_q[$];
   logic [31:0] model [int];

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   mips32_mem_responder_if bus();

   mips32_mem_responder #(.DEPTH(DEPTH), .LATENCY(LATENCY)) dut (
      .clk(clk),
      .rst(rst),
      .bus(bus)
   );

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h, expected %h (cycle %0d)", name, act, exp, cyc);
      end
   endtask

   task automatic flag(input string name);
      n_checks++;
      n_fail++;
      $display("FAIL %s (cycle %0d)", name, cyc);
   endtask

   // Reference model: word memory indexed modulo DEPTH, bounds rule from the macro.
   function automatic void predict(input bit is_d, input bit we, input logic [31:0] addr,
                                   input logic [31:0] wdata, input int due);
      exp_t e;
      bit   oob;
      int   idx;
`ifdef MEM_BOUNDS_CHECK_EN
      oob = (addr >= DEPTH);
`else
      oob = 1'b0;
`endif
      idx   = int'(addr % DEPTH);
      e.due = due;
      e.err = oob;
      e.chk = 1'b1;
      e.data = 32'd0;
      if (oob) begin
         e.data = 32'd0;
      end else if (is_d && we) begin
         model[idx] = wdata;
      end else if (model.exists(idx)) begin
         e.data = model[idx];
      end else begin
         e.chk = 1'b0;
      end
      if (is_d) d_q.push_back(e);
      else      i_q.push_back(e);
   endfunction

   // Monitor: pop and compare whenever a response pulse is seen; flag missing ones.
   always @(negedge clk) begin
      exp_t e;
      if (!rst) begin
         if (bus.i_req_valid && bus.d_req_valid && bus.i_req_ready && bus.d_req_ready)
            flag("ready_exclusive both ports ready");
         if (bus.i_rsp_valid) begin
            if (i_q.size() == 0) begin
               flag("i_rsp unexpected pulse");
            end else begin
               e = i_q.pop_front();
               check("i_rsp_cycle", cyc, e.due);
               check("i_rsp_err", {31'd0, bus.i_rsp_err}, {31'd0, e.err});
               if (e.chk) check("i_rsp_data", bus.i_rsp_data, e.data);
            end
         end else if (i_q.size() > 0 && i_q[0].due < cyc) begin
            flag("i_rsp missing");
            void'(i_q.pop_front());
         end
         if (bus.d_rsp_valid) begin
            if (d_q.size() == 0) begin
               flag("d_rsp unexpected pulse");
            end else begin
               e = d_q.pop_front();
               check("d_rsp_cycle", cyc, e.due);
               check("d_rsp_err", {31'd0, bus.d_rsp_err}, {31'd0, e.err});
               if (e.chk) check("d_rsp_rdata", bus.d_rsp_rdata, e.data);
            end
         end else if (d_q.size() > 0 && d_q[0].due < cyc) begin
            flag("d_rsp missing");
            void'(d_q.pop_front());
         end
      end
   end

   // Caller is aligned at posedge+1; returns at posedge+1 after the accept edge.
   task automatic d_issue(input bit we, input logic [31:0] addr, input logic [31:0] wdata, input bit track);
      int waited = 0;
      bus.d_req_valid = 1'b1;
      bus.d_req_we    = we;
      bus.d_req_addr  = addr;
      bus.d_req_wdata = wdata;
      do begin
         @(negedge clk);
         waited++;
      end while (!bus.d_req_ready && waited < 50);
      if (bus.d_req_ready) begin
         if (track) predict(1'b1, we, addr, wdata, cyc + 1 + LATENCY);
      end else begin
         flag("d_accept timeout");
      end
      @(posedge clk);
      #1;
      bus.d_req_valid = 1'b0;
      bus.d_req_we    = $urandom_range(0, 1);
      bus.d_req_addr  = $urandom;
      bus.d_req_wdata = $urandom;
   endtask

   task automatic i_issue(input logic [31:0] addr);
      int waited = 0;
      bus.i_req_valid = 1'b1;
      bus.i_req_addr  = addr;
      do begin
         @(negedge clk);
         waited++;
      end while (!bus.i_req_ready && waited < 50);
      if (bus.i_req_ready) predict(1'b0, 1'b0, addr, 32'd0, cyc + 1 + LATENCY);
      else                 flag("i_accept timeout");
      @(posedge clk);
      #1;
      bus.i_req_valid = 1'b0;
      bus.i_req_addr  = $urandom;
   endtask

   task automatic idle(input int n);
      repeat (n) @(posedge clk);
      #1;
   endtask

   task automatic pulse_reset();
      rst = 1'b1;
      idle(2);
      rst = 1'b0;
   endtask

   // Both ports held valid: grants must alternate starting with D, ready low during WAIT.
   task automatic both_valid(input int k, input logic [31:0] d_addr, input logic [31:0] i_addr);
      bit exp_d = 1'b1;
      int waited;
      bus.d_req_valid = 1'b1;
      bus.d_req_we    = 1'b0;
      bus.d_req_addr  = d_addr;
      bus.i_req_valid = 1'b1;
      bus.i_req_addr  = i_addr;
      for (int t = 0; t < k; t++) begin
         waited = 0;
         do begin
            @(negedge clk);
            waited++;
         end while (!(bus.d_req_ready || bus.i_req_ready) && waited < 50);
         if (t > 0) check("rearm_in_response_cycle", waited, 1);
         check("grant_d", {31'd0, bus.d_req_ready}, {31'd0, exp_d});
         check("grant_i", {31'd0, bus.i_req_ready}, {31'd0, !exp_d});
         if (bus.d_req_ready)      predict(1'b1, 1'b0, d_addr, 32'd0, cyc + 1 + LATENCY);
         else if (bus.i_req_ready) predict(1'b0, 1'b0, i_addr, 32'd0, cyc + 1 + LATENCY);
         else                      flag("both_valid no grant");
         for (int w = 0; w < LATENCY; w++) begin
            @(negedge clk);
            check("ready_low_in_wait", {30'd0, bus.d_req_ready, bus.i_req_ready}, 32'd0);
         end
         exp_d = !exp_d;
      end
      @(posedge clk);
      #1;
      bus.d_req_valid = 1'b0;
      bus.i_req_valid = 1'b0;
   endtask

   function automatic logic [31:0] pick_addr();
      case ($urandom_range(0, 9))
         0:       return 32'd1023;
         1:       return 32'd1024 + 32'($urandom_range(0, 7));
         2:       return 32'h8000_0000 | 32'($urandom_range(0, 15));
         default: return 32'($urandom_range(0, 15));
      endcase
   endfunction

   task automatic d_random(input int n);
      for (int t = 0; t < n; t++) begin
         idle($urandom_range(0, 3));
         d_issue($urandom_range(0, 1), pick_addr(), $urandom, 1'b1);
      end
   endtask

   task automatic i_random(input int n);
      for (int t = 0; t < n; t++) begin
         idle($urandom_range(0, 3));
         i_issue(pick_addr());
      end
   endtask

   initial begin
      bus.i_req_valid = 1'b0;
      bus.i_req_addr  = 32'd0;
      bus.d_req_valid = 1'b0;
      bus.d_req_we    = 1'b0;
      bus.d_req_addr  = 32'd0;
      bus.d_req_wdata = 32'd0;
      rst = 1'b1;
      repeat (3) @(posedge clk);
      @(negedge clk);
      check("reset i_rsp_valid", {31'd0, bus.i_rsp_valid}, 32'd0);
      check("reset d_rsp_valid", {31'd0, bus.d_rsp_valid}, 32'd0);
      check("reset i_rsp_data", bus.i_rsp_data, 32'd0);
      check("reset d_rsp_rdata", bus.d_rsp_rdata, 32'd0);
      check("reset errs", {30'd0, bus.i_rsp_err, bus.d_rsp_err}, 32'd0);
      @(posedge clk);
      #1;
      rst = 1'b0;

      // Store then fetch the same word; fetch lands in the store's response cycle.
      d_issue(1'b1, 32'd5, 32'hDEAD_BEEF, 1'b1);
      idle(LATENCY);
      i_issue(32'd5);
      idle(LATENCY + 2);

      // Arbitration from reset: D, I, D, I.
      pulse_reset();
      both_valid(4, 32'd5, 32'd5);
      idle(LATENCY + 2);

      // Reset during WAIT cancels the store and its response.
      d_issue(1'b1, 32'd7, 32'h0BAD_F00D, 1'b1);
      idle(LATENCY + 1);
      d_issue(1'b1, 32'd7, 32'h0000_1234, 1'b0);
      rst = 1'b1;
      @(posedge clk);
      #1;
      rst = 1'b0;
      for (int w = 0; w < LATENCY + 2; w++) begin
         @(negedge clk);
         check("no d_rsp after reset", {31'd0, bus.d_rsp_valid}, 32'd0);
      end
      idle(1);
      d_issue(1'b0, 32'd7, 32'd0, 1'b1);
      idle(LATENCY + 1);

      // Boundary words and the first address past the end.
      d_issue(1'b1, 32'd1023, 32'hA5A5_A5A5, 1'b1);
      d_issue(1'b0, 32'd1023, 32'd0, 1'b1);
      d_issue(1'b1, 32'd0, 32'h1111_1111, 1'b1);
      d_issue(1'b1, 32'd1024, 32'h2222_2222, 1'b1);
      d_issue(1'b0, 32'd0, 32'd0, 1'b1);
      i_issue(32'd1024);
      idle(LATENCY + 2);

      // Randomized concurrent traffic on both ports.
      fork
         d_random(60);
         i_random(60);
      join
      idle(LATENCY + 3);
      check("scoreboard drained", i_q.size() + d_q.size(), 32'd0);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

   initial begin
      #400000;
      $display("FAIL watchdog: simulation did not complete (cycle %0d)", cyc);
      $fatal(1, "watchdog");
   end
endmodule
